udp_tx_packetizer: RTL and testbench
====================================

Name: udp_tx_packetizer

Overview:
- Sits directly upstream of the UDP stack's send port and feeds it.
- Accepts a free-running byte stream, for example serialized audio samples, and buffers it in an internal FIFO.
- Emits UDP payload frames of fixed length P_PAYLOAD_LEN, or a shorter flush frame after an idle timeout.
- Frames are sent contiguously and are gated by the stack's send-ready.

Parameters:
- P_PAYLOAD_LEN, 1024: bytes per full frame; legal range 1..P_FIFO_DEPTH.
- P_FIFO_DEPTH, 2048: buffer depth in bytes; must be a power of 2.
- P_TIMEOUT, 125000: idle cycles (no write) with FIFO non-empty before a partial flush frame is sent.
- P_GAP, 16: minimum idle cycles between the last byte of one frame and the first byte of the next.

Ports:
- i_clk  in  1  single clock.
- i_rst  in  1  asynchronous active-high reset.
- i_data  in  8  user byte.
- i_data_valid  in  1  byte strobe; there is no backpressure on this port.
- o_send_len  out  16  payload length of the current frame.
- o_send_data  out  8  payload byte.
- o_send_last  out  1  high on the final byte of a frame.
- o_send_valid  out  1  payload byte valid.
- i_send_ready  in  1  stack ready; sampled only at frame start.
- o_overflow  out  1  one-cycle pulse when a byte is dropped.
- o_drop_cnt  out  16  saturating count of dropped bytes.
- o_fifo_level  out  clog2(P_FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clocking and reset:
  - One clock, i_clk.
  - Reset i_rst is asynchronous and active-high.
  - All outputs reset to 0; FIFO pointers, level, timeout counter and drop count reset to 0; FSM resets to IDLE.
- Write side:
  - A byte is accepted when i_data_valid=1 and level<P_FIFO_DEPTH, where level is the registered value.
  - When full, the byte is dropped, o_overflow pulses for one cycle and o_drop_cnt increments, saturating at 16'hFFFF.
  - A write arriving when full is dropped even if a read occurs in the same cycle.
  - A simultaneous read and write when not full leaves the level unchanged.
- Timeout counter:
  - Clears on every accepted write and on frame start.
  - Otherwise increments while level>0, saturating at P_TIMEOUT.
- FSM states: IDLE, WAIT_RDY, SEND, GAP.
  - IDLE -> WAIT_RDY when level>=P_PAYLOAD_LEN (frame_len=P_PAYLOAD_LEN), or when timeout counter==P_TIMEOUT and level>0 (frame_len=level). The full-frame condition has priority.
  - WAIT_RDY: frame_len is already latched. Stays here while i_send_ready=0.
  - WAIT_RDY -> SEND when i_send_ready=1. The first FIFO read is issued in that cycle.
  - SEND: one FIFO read per cycle. FIFO read latency is 1, so o_send_valid rises exactly 1 cycle after the WAIT_RDY->SEND transition.
  - SEND: o_send_valid stays high for exactly frame_len consecutive cycles with no bubbles. i_send_ready is ignored once the frame has started.
  - SEND: o_send_len=frame_len and is stable for the whole frame while o_send_valid=1, and 0 otherwise.
  - SEND: o_send_last=1 only on the byte with index frame_len-1, then -> GAP.
  - GAP: counts P_GAP cycles with o_send_valid=0, then -> IDLE.
- Byte order: bytes are output in arrival order; no reordering and no duplication.
- Width rules:
  - Byte counter is 16 bits and compares against frame_len-1.
  - Level and pointers are clog2(P_FIFO_DEPTH)+1 bits; pointers wrap modulo the depth.
- Writes during SEND and GAP continue normally. Bytes arriving after frame_len is latched belong to the next frame.
- Reset mid-frame: o_send_valid and o_send_last drop to 0 asynchronously and buffered data is discarded. The stack sees a truncated frame; this is accepted behaviour.

Decomposition:
- Shared package udp_pkt_pkg contains:
  - FSM state encodings (2-bit: IDLE=0, WAIT_RDY=1, SEND=2, GAP=3).
  - Width helper constants derived from clog2(P_FIFO_DEPTH).
  - Default timing constants (P_TIMEOUT, P_GAP).
- One sub-module: byte_sync_fifo.
  - Single-clock, depth P_FIFO_DEPTH, 8-bit wide.
  - Registered read data with 1-cycle latency.
  - Provides full, empty and level outputs.
  - Maps to block RAM.
- The FSM, timeout counter and drop counter live in the top level.

Test Plan:
1. Write 1024 bytes 0x00..0xFF repeating, i_send_ready=1 -> one frame: o_send_len=1024, 1024 contiguous valids, data matches, o_send_last on byte 1024 only, level returns to 0.
2. Write 100 bytes then stop, P_TIMEOUT=1000 -> after 1000 idle cycles a frame with o_send_len=100 and last on byte 100; no frame before the timeout.
3. Buffer 1024 bytes with i_send_ready=0 for 500 cycles -> o_send_valid stays 0; raise ready -> first valid exactly 1 cycle after WAIT_RDY->SEND.
4. Write 2049 bytes with ready low (depth 2048) -> o_overflow pulses once, o_drop_cnt=1, level=2048; subsequent frames contain the first 2048 bytes in order.
5. Write 3000 bytes continuously, ready=1 -> frames of 1024 and 1024, then 952 after the timeout; at least P_GAP=16 idle cycles between frames; all bytes in order with no loss.
6. Assert i_rst at byte 500 of a frame -> outputs 0 in the same cycle, level=0, o_drop_cnt=0; after release, a new 1024-byte write yields a clean frame.

Source files
------------

// File: rtl/udp_pkt_pkg.sv
// rtl/udp_pkt_pkg.sv - shared states, widths and default timing for the UDP tx packetizer
package udp_pkt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RDY = 2'd1,
    ST_SEND     = 2'd2,
    ST_GAP      = 2'd3
  } state_t;

  localparam int DEF_PAYLOAD_LEN = 1024;
  localparam int DEF_FIFO_DEPTH  = 2048;
  localparam int DEF_ADDR_W      = $clog2(DEF_FIFO_DEPTH);
  localparam int DEF_LEVEL_W     = DEF_ADDR_W + 1;
  localparam int DEF_TIMEOUT     = 125000;
  localparam int DEF_GAP         = 16;
  localparam int LEN_W           = 16;

endpackage

// File: rtl/udp_tx_packetizer_byte_sync_fifo.sv
// rtl/udp_tx_packetizer_byte_sync_fifo.sv - single-clock byte FIFO with registered read data
module byte_sync_fifo
  import udp_pkt_pkg::*;
#(
  parameter int  DEPTH = DEF_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [7:0]    mem [DEPTH];
  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Storage and read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    if (do_rd) rd_data <= mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + LW'(1);
      if (do_rd) rd_ptr <= rd_ptr + LW'(1);
      case ({do_wr, do_rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/udp_tx_packetizer.sv
// rtl/udp_tx_packetizer.sv - buffers a byte stream and emits fixed-length or timeout-flushed UDP payload frames
module udp_tx_packetizer
  import udp_pkt_pkg::*;
#(
  parameter int  P_PAYLOAD_LEN = DEF_PAYLOAD_LEN,
  parameter int  P_FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int  P_TIMEOUT     = DEF_TIMEOUT,
  parameter int  P_GAP         = DEF_GAP,
  localparam int LW            = $clog2(P_FIFO_DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_data,
  input  logic             i_data_valid,
  output logic [LEN_W-1:0] o_send_len,
  output logic [7:0]       o_send_data,
  output logic             o_send_last,
  output logic             o_send_valid,
  input  logic             i_send_ready,
  output logic             o_overflow,
  output logic [15:0]      o_drop_cnt,
  output logic [LW-1:0]    o_fifo_level
);

  localparam int TW = $clog2(P_TIMEOUT + 1);
  localparam int GW = $clog2(P_GAP + 1);

  state_t           state;
  logic [LEN_W-1:0] frame_len;
  logic [LEN_W-1:0] rd_cnt;
  logic [LEN_W-1:0] rd_idx;
  logic [TW-1:0]    tmo_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [7:0]       fifo_rd_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LW-1:0]    fifo_level;
  logic             wr_accept;
  logic             wr_drop;
  logic             start_frame;
  logic             rd_en;
  logic             last_rd;

  assign wr_accept   = i_data_valid && !fifo_full;
  assign wr_drop     = i_data_valid && fifo_full;
  assign start_frame = (state == ST_WAIT_RDY) && i_send_ready;
  assign rd_en       = start_frame || ((state == ST_SEND) && (rd_cnt != frame_len));
  assign rd_idx      = start_frame ? '0 : rd_cnt;
  assign last_rd     = (rd_idx == frame_len - LEN_W'(1));

  assign o_send_data  = o_send_valid ? fifo_rd_data : 8'h00;
  assign o_fifo_level = fifo_level;

  byte_sync_fifo #(.DEPTH(P_FIFO_DEPTH)) u_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr_en   (wr_accept),
    .wr_data (i_data),
    .rd_en   (rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Outputs are the read strobe delayed by one cycle, matching the FIFO read latency.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      frame_len    <= '0;
      rd_cnt       <= '0;
      gap_cnt      <= '0;
      o_send_valid <= 1'b0;
      o_send_last  <= 1'b0;
      o_send_len   <= '0;
    end else begin
      o_send_valid <= rd_en;
      o_send_last  <= rd_en && last_rd;
      o_send_len   <= rd_en ? frame_len : '0;
      case (state)
        ST_IDLE: begin
          if (fifo_level >= LW'(P_PAYLOAD_LEN)) begin
            frame_len <= LEN_W'(P_PAYLOAD_LEN);
            state     <= ST_WAIT_RDY;
          end else if ((tmo_cnt == TW'(P_TIMEOUT)) && !fifo_empty) begin
            frame_len <= LEN_W'(fifo_level);
            state     <= ST_WAIT_RDY;
          end
        end
        ST_WAIT_RDY: begin
          if (i_send_ready) begin
            rd_cnt <= LEN_W'(1);
            state  <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (rd_en) rd_cnt <= rd_cnt + LEN_W'(1);
          if (o_send_valid && o_send_last) begin
            gap_cnt <= '0;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GW'(P_GAP - 1)) state <= ST_IDLE;
          else gap_cnt <= gap_cnt + GW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tmo_cnt <= '0;
    end else if (wr_accept || start_frame) begin
      tmo_cnt <= '0;
    end else if (!fifo_empty && (tmo_cnt != TW'(P_TIMEOUT))) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      o_overflow <= wr_drop;
      if (wr_drop && (o_drop_cnt != 16'hFFFF)) o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// tb/tb_udp_tx_packetizer.sv - self-checking bench for udp_tx_packetizer
module tb_udp_tx_packetizer;

  localparam int PL    = 1024;
  localparam int DEPTH = 2048;
  localparam int TMO   = 1000;
  localparam int GAP   = 16;
  localparam int LW    = 12;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [7:0]    i_data = 8'h00;
  logic          i_data_valid = 1'b0;
  logic [15:0]   o_send_len;
  logic [7:0]    o_send_data;
  logic          o_send_last;
  logic          o_send_valid;
  logic          i_send_ready = 1'b0;
  logic          o_overflow;
  logic [15:0]   o_drop_cnt;
  logic [LW-1:0] o_fifo_level;

  always #5 i_clk = ~i_clk;

  udp_tx_packetizer #(
    .P_PAYLOAD_LEN (PL),
    .P_FIFO_DEPTH  (DEPTH),
    .P_TIMEOUT     (TMO),
    .P_GAP         (GAP)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .o_send_len   (o_send_len),
    .o_send_data  (o_send_data),
    .o_send_last  (o_send_last),
    .o_send_valid (o_send_valid),
    .i_send_ready (i_send_ready),
    .o_overflow   (o_overflow),
    .o_drop_cnt   (o_drop_cnt),
    .o_fifo_level (o_fifo_level)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int ovf_pulses = 0;
  byte unsigned q[$];
  int frame_lens[$];
  bit in_frame = 0;
  bit have_end = 0;
  int cur_len = 0;
  int idx = 0;
  int end_cyc = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int len_at(input int i);
    return (i < frame_lens.size()) ? frame_lens[i] : -1;
  endfunction

  // Reference model: bytes accepted in arrival order, frame rules applied at each frame's first byte.
  always @(negedge i_clk) begin
    if (i_rst) begin
      in_frame = 0;
      have_end = 0;
      q.delete();
    end else begin
      if (o_overflow) ovf_pulses++;
      if (o_send_valid) begin
        if (!in_frame) begin
          in_frame = 1;
          idx = 0;
          cur_len = int'(o_send_len);
          if (have_end) chk("gap_idle_cycles_ok", longint'((cyc - end_cyc - 1) >= GAP), 1);
          if (q.size() >= PL) begin
            chk("full_frame_len", o_send_len, PL);
          end else begin
            chk("flush_frame_len", o_send_len, q.size());
            chk("flush_after_timeout_window",
                longint'((cyc - last_wr_cyc) >= TMO && (cyc - last_wr_cyc) <= TMO + 8), 1);
          end
        end
        chk("send_len_stable", o_send_len, cur_len);
        chk("model_has_byte", longint'(q.size() > 0), 1);
        if (q.size() > 0) chk("send_data", o_send_data, q.pop_front());
        chk("send_last", o_send_last, longint'(idx == cur_len - 1));
        idx++;
        if (idx == cur_len) begin
          in_frame = 0;
          frame_lens.push_back(cur_len);
          have_end = 1;
          end_cyc = cyc;
        end
      end else begin
        chk("idle_len_zero", o_send_len, 0);
        chk("idle_last_zero", o_send_last, 0);
        chk("no_bubble_in_frame", in_frame, 0);
        in_frame = 0;
      end
    end
  end

  task automatic write_bytes(input int n, input int mul, input int seed, input int keep);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk); #1;
      i_data = 8'((i * mul + seed) & 255);
      i_data_valid = 1'b1;
      if (i < keep) q.push_back(i_data);
      last_wr_cyc = cyc;
    end
    @(posedge i_clk); #1;
    i_data_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int k = 0;
    while (frame_lens.size() < n && k < budget) begin
      @(negedge i_clk); #1;
      k++;
    end
    chk(name, frame_lens.size(), n);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
    #1;
  endtask

  initial begin
    int vcount;
    int k;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", o_send_valid, 0);
    chk("rst_last", o_send_last, 0);
    chk("rst_len", o_send_len, 0);
    chk("rst_data", o_send_data, 0);
    chk("rst_overflow", o_overflow, 0);
    chk("rst_drop_cnt", o_drop_cnt, 0);
    chk("rst_level", o_fifo_level, 0);
    i_rst = 1'b0;

    // 1: one full frame of 0x00..0xFF repeating
    i_send_ready = 1'b1;
    write_bytes(1024, 1, 0, 1024);
    wait_frames(1, 3000, "t1_frame_count");
    chk("t1_len", len_at(0), 1024);
    idle(3);
    chk("t1_level_zero", o_fifo_level, 0);

    // 2: short burst flushed by timeout
    write_bytes(100, 3, 5, 100);
    idle(900);
    chk("t2_no_early_frame", frame_lens.size(), 1);
    wait_frames(2, 400, "t2_frame_count");
    chk("t2_len", len_at(1), 100);

    // 3: ready held low, then first valid one cycle after ready
    idle(GAP + 4);
    i_send_ready = 1'b0;
    write_bytes(1024, 7, 11, 1024);
    vcount = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge i_clk);
      vcount += int'(o_send_valid);
    end
    chk("t3_no_valid_while_not_ready", vcount, 0);
    chk("t3_level_buffered", o_fifo_level, 1024);
    @(posedge i_clk); #1;
    i_send_ready = 1'b1;
    @(negedge i_clk);
    chk("t3_valid_before_start", o_send_valid, 0);
    @(negedge i_clk);
    chk("t3_valid_one_cycle_after_start", o_send_valid, 1);
    wait_frames(3, 1500, "t3_frame_count");
    chk("t3_len", len_at(2), 1024);

    // 4: overflow by one byte while ready is low
    idle(GAP + 4);
    i_send_ready = 1'b0;
    ovf_pulses = 0;
    write_bytes(2049, 5, 23, 2048);
    idle(3);
    chk("t4_overflow_pulses", ovf_pulses, 1);
    chk("t4_drop_cnt", o_drop_cnt, 1);
    chk("t4_level_full", o_fifo_level, 2048);
    i_send_ready = 1'b1;
    wait_frames(5, 3000, "t4_frame_count");
    chk("t4_len_a", len_at(3), 1024);
    chk("t4_len_b", len_at(4), 1024);
    idle(3);
    chk("t4_level_zero", o_fifo_level, 0);

    // 5: continuous stream of 3000 bytes
    idle(GAP + 4);
    write_bytes(3000, 13, 37, 3000);
    wait_frames(8, TMO + 2000, "t5_frame_count");
    chk("t5_len_a", len_at(5), 1024);
    chk("t5_len_b", len_at(6), 1024);
    chk("t5_len_c", len_at(7), 952);
    chk("t5_model_drained", q.size(), 0);
    idle(3);
    chk("t5_level_zero", o_fifo_level, 0);

    // 6: reset in the middle of a frame, then a clean frame
    idle(GAP + 4);
    write_bytes(1024, 1, 41, 1024);
    k = 0;
    while (!(in_frame && idx == 500) && k < 3000) begin
      @(negedge i_clk); #1;
      k++;
    end
    chk("t6_reached_byte_500", idx, 500);
    chk("t6_valid_before_reset", o_send_valid, 1);
    #2;
    i_rst = 1'b1;
    #1;
    chk("t6_rst_valid", o_send_valid, 0);
    chk("t6_rst_last", o_send_last, 0);
    chk("t6_rst_len", o_send_len, 0);
    chk("t6_rst_data", o_send_data, 0);
    chk("t6_rst_level", o_fifo_level, 0);
    chk("t6_rst_drop_cnt", o_drop_cnt, 0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    write_bytes(1024, 9, 53, 1024);
    wait_frames(9, 3000, "t6_frame_count");
    chk("t6_len", len_at(8), 1024);
    idle(3);
    chk("t6_level_zero", o_fifo_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected under 500000", cyc);
    $fatal(1, "watchdog");
  end

endmodule
